event_writer: RTL and testbench

//  Capture side of the event FIFO. Watches the detector hit lines and opens a coincidence window on the

---
 rtl/muon_daq_pkg.sv | 40 ++++
 rtl/event_writer_if.sv | 12 +
 rtl/event_timestamp.sv | 24 ++
 rtl/event_writer.sv | 109 ++++++++++
 tb/tb_event_writer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/muon_daq_pkg.sv
// Shared definitions for the muon DAQ event path: event word layout,
// writer FSM states and the command bytes understood by the FIFO reader.
package muon_daq_pkg;

  localparam int EVT_WIDTH    = 64;
  localparam int EVT_TS_MSB   = 63;
  localparam int EVT_TS_LSB   = 24;
  localparam int EVT_ID_MSB   = 23;
  localparam int EVT_ID_LSB   = 16;
  localparam int EVT_MASK_MSB = 15;
  localparam int EVT_MASK_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DEADTIME = 2'd3
  } writer_state_t;

  // Reader drains each 64-bit word as two 32-bit halves, upper half first.
  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_READ_HI  = 8'h01;
  localparam logic [7:0] CMD_READ_LO  = 8'h02;
  localparam logic [7:0] CMD_STATUS   = 8'h03;
  localparam logic [7:0] CMD_CLR_DROP = 8'h04;

  function automatic logic [EVT_WIDTH-1:0] pack_event(
    input logic [EVT_TS_MSB-EVT_TS_LSB:0]     ts,
    input logic [EVT_ID_MSB-EVT_ID_LSB:0]     id,
    input logic [EVT_MASK_MSB-EVT_MASK_LSB:0] mask
  );
    logic [EVT_WIDTH-1:0] word;
    word                              = {EVT_WIDTH{1'b0}};
    word[EVT_TS_MSB:EVT_TS_LSB]       = ts;
    word[EVT_ID_MSB:EVT_ID_LSB]       = id;
    word[EVT_MASK_MSB:EVT_MASK_LSB]   = mask;
    return word;
  endfunction

endpackage

// File: rtl/event_writer_if.sv
// Write side of the 64-bit event FIFO: strobe and data towards the FIFO,
// full flag back from it.
interface event_writer_if;
  import muon_daq_pkg::*;

  logic                 wr_en;
  logic [EVT_WIDTH-1:0] din;
  logic                 full;

  modport master (output wr_en, output din, input full);
  modport slave  (input wr_en, input din, output full);
endinterface

// File: rtl/event_timestamp.sv
// Free-running timestamp counter; wraps naturally at 2^TS_WIDTH.
// Shared by every block that stamps data with the common time base.
module event_timestamp #(
  parameter int TS_WIDTH = 40
) (
  input  logic                clk,
  input  logic                rst,
  output logic [TS_WIDTH-1:0] ts_o
);

  logic [TS_WIDTH-1:0] ts_q;

  // Counter runs every cycle regardless of any capture arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= {TS_WIDTH{1'b0}};
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  assign ts_o = ts_q;

endmodule

// File: rtl/event_writer.sv
// Capture side of the event FIFO: opens a coincidence window on the first hit
// rising edge, then writes one {timestamp, event_id, hit_mask} word per event.
module event_writer
  import muon_daq_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int TS_WIDTH = 40,
  parameter int WINDOW   = 8,
  parameter int DEADTIME = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [N_CH-1:0]  hits_i,
  event_writer_if.master   fifo,
  output logic             busy_o,
  output logic [15:0]      dropped_o
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int DT_W  = $clog2(DEADTIME + 1);

  if (TS_WIDTH + 8 + N_CH != EVT_WIDTH) begin : g_bad_event_format
    $error("event_writer: TS_WIDTH + 8 + N_CH must equal 64");
  end

  writer_state_t        state_q;
  logic [N_CH-1:0]      hits_q;
  logic [N_CH-1:0]      mask_q;
  logic [N_CH-1:0]      rise;
  logic [TS_WIDTH-1:0]  ts;
  logic [TS_WIDTH-1:0]  ts_lat_q;
  logic [7:0]           event_id_q;
  logic [WIN_W-1:0]     win_cnt_q;
  logic [DT_W-1:0]      dead_cnt_q;
  logic [EVT_WIDTH-1:0] din_q;
  logic [15:0]          dropped_q;

  event_timestamp #(.TS_WIDTH(TS_WIDTH)) u_timestamp (
    .clk  (clk),
    .rst  (rst),
    .ts_o (ts)
  );

  assign rise = hits_i & ~hits_q;

  // Writer FSM with its capture registers; hits_q tracks the lines in every
  // state so a line held high through DEADTIME never looks like a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hits_q     <= {N_CH{1'b0}};
      mask_q     <= {N_CH{1'b0}};
      ts_lat_q   <= {TS_WIDTH{1'b0}};
      event_id_q <= 8'd0;
      win_cnt_q  <= {WIN_W{1'b0}};
      dead_cnt_q <= {DT_W{1'b0}};
      din_q      <= {EVT_WIDTH{1'b0}};
      dropped_q  <= 16'd0;
    end else begin
      hits_q <= hits_i;
      case (state_q)
        ST_IDLE: begin
          if (enable_i && (|rise)) begin
            state_q   <= ST_CAPTURE;
            ts_lat_q  <= ts;
            mask_q    <= rise;
            win_cnt_q <= {WIN_W{1'b0}};
          end
        end
        ST_CAPTURE: begin
          mask_q <= mask_q | rise;
          if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            // Last window cycle still contributes its edges to the word.
            state_q <= ST_WRITE;
            din_q   <= pack_event(ts_lat_q, event_id_q, mask_q | rise);
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
          end
        end
        ST_WRITE: begin
          // The id advances even on a drop so the reader can see the gap.
          event_id_q <= event_id_q + 8'd1;
          if (fifo.full && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
          end
          dead_cnt_q <= {DT_W{1'b0}};
          state_q    <= ST_DEADTIME;
        end
        ST_DEADTIME: begin
          if (dead_cnt_q == DT_W'(DEADTIME - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            dead_cnt_q <= dead_cnt_q + DT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo.wr_en = (state_q == ST_WRITE) && !fifo.full;
  assign fifo.din   = din_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_event_writer.sv
// Scoreboard bench for event_writer: expected event words are queued when a
// hit is driven and compared when the FIFO write strobe fires.
module tb_event_writer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] hits;
  logic        busy;
  logic [15:0] dropped;
  logic [3:0]  ts4;

  event_writer_if fifo ();

  event_writer #(.N_CH(16), .TS_WIDTH(40), .WINDOW(8), .DEADTIME(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enable),
    .hits_i    (hits),
    .fifo      (fifo),
    .busy_o    (busy),
    .dropped_o (dropped)
  );

  // Narrow copy of the counter so the wrap can be seen within a short run.
  event_timestamp #(.TS_WIDTH(4)) u_ts4 (
    .clk  (clk),
    .rst  (rst),
    .ts_o (ts4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n_writes = 0;
  logic [39:0] cyc;
  logic [7:0]  exp_id;
  logic [15:0] exp_drop;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference time base: counts posedges since the last reset.
  always @(posedge clk) begin
    if (rst) cyc <= 40'd0;
    else     cyc <= cyc + 40'd1;
  end

  // Scoreboard: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo.wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("din", fifo.din, mon_exp);
      end
    end
  end

  task automatic run_event(input logic [15:0] m);
    hits = m;
    if (!fifo.full) exp_q.push_back({cyc, exp_id, m});
    else            exp_drop = exp_drop + 16'd1;
    exp_id = exp_id + 8'd1;
    @(negedge clk);
    hits = 16'h0000;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int lat;
    int w0;
    logic [15:0] m;

    rst = 1'b1; enable = 1'b0; hits = 16'h0000; fifo.full = 1'b0;
    exp_id = 8'd0; exp_drop = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_wr_en", {63'd0, fifo.wr_en}, 64'd0);
    check_eq("rst_din", fifo.din, 64'd0);
    check_eq("rst_dropped", {48'd0, dropped}, 64'd0);
    rst = 1'b0; enable = 1'b1;

    // 1: single hit at t=10, latency and deadtime length
    while (cyc != 40'd10) @(negedge clk);
    hits = 16'h0001;
    exp_q.push_back({40'd10, 8'd0, 16'h0001});
    exp_id = 8'd1;
    @(negedge clk);
    hits = 16'h0000;
    check_eq("busy_capture", {63'd0, busy}, 64'd1);
    lat = 1;
    while (fifo.wr_en !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("wr_latency", 64'(lat), 64'd9);
    lat = 0;
    while (busy === 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("deadtime_len", 64'(lat), 64'd17);
    check_eq("idle_at_36", cyc, 40'd36);

    // 2: rises across the window, late rise in WRITE is excluded
    repeat (5) @(negedge clk);
    w0 = n_writes;
    hits = 16'h0001;
    exp_q.push_back({cyc, exp_id, 16'h8021});
    exp_id = exp_id + 8'd1;
    repeat (4) @(negedge clk);
    hits = 16'h0021;
    repeat (4) @(negedge clk);
    hits = 16'h8021;
    @(negedge clk);
    hits = 16'h8029;
    repeat (20) @(negedge clk);
    hits = 16'h0000;
    repeat (10) @(negedge clk);
    check_eq("window_one_write", 64'(n_writes - w0), 64'd1);
    check_eq("ts_wrap_a", {60'd0, ts4}, {60'd0, cyc[3:0]});

    // 3: FIFO full during WRITE drops the event but consumes its id
    w0 = n_writes;
    fifo.full = 1'b1;
    run_event(16'h0004);
    fifo.full = 1'b0;
    check_eq("full_no_write", 64'(n_writes - w0), 64'd0);
    check_eq("dropped_one", {48'd0, dropped}, {48'd0, exp_drop});
    run_event(16'h0100);

    // 4: lines held high do not retrigger after deadtime
    w0 = n_writes;
    hits = 16'hFFFF;
    exp_q.push_back({cyc, exp_id, 16'hFFFF});
    exp_id = exp_id + 8'd1;
    repeat (80) @(negedge clk);
    hits = 16'h0000;
    repeat (5) @(negedge clk);
    check_eq("held_one_write", 64'(n_writes - w0), 64'd1);

    // Rise during deadtime is discarded
    w0 = n_writes;
    hits = 16'h0010;
    exp_q.push_back({cyc, exp_id, 16'h0010});
    exp_id = exp_id + 8'd1;
    @(negedge clk);
    hits = 16'h0000;
    repeat (14) @(negedge clk);
    hits = 16'h0040;
    @(negedge clk);
    hits = 16'h0000;
    repeat (20) @(negedge clk);
    check_eq("deadtime_ignored", 64'(n_writes - w0), 64'd1);

    // 5: event_id wraps 255 -> 0
    while (exp_id != 8'hFF) begin
      m = 16'($urandom_range(1, 65535));
      run_event(m);
    end
    run_event(16'h0f0f);
    check_eq("id_wrapped_model", {56'd0, exp_id}, 64'd0);
    run_event(16'h00f0);
    check_eq("ts_wrap_b", {60'd0, ts4}, {60'd0, cyc[3:0]});

    // 6: disabled capture, then reset in the middle of CAPTURE
    w0 = n_writes;
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      hits = 16'($urandom);
      @(negedge clk);
    end
    hits = 16'h0000;
    @(negedge clk);
    check_eq("disabled_no_write", 64'(n_writes - w0), 64'd0);
    check_eq("disabled_idle", {63'd0, busy}, 64'd0);
    enable = 1'b1;
    hits = 16'h0001;
    @(negedge clk);
    hits = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_id = 8'd0; exp_drop = 16'd0;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_wr_en", {63'd0, fifo.wr_en}, 64'd0);
    check_eq("midrst_din", fifo.din, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_write", 64'(n_writes - w0), 64'd0);
    run_event(16'h1234);
    check_eq("dropped_final", {48'd0, dropped}, {48'd0, exp_drop});
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
